lreport: RTL and testbench
==========================

LREPORT -- requirements
Module: lreport

Interface
REQ-001 Parameter LMID, default 8'd12, local module ID placed in generated metadata.
REQ-002 Parameter ALF_TH, default 9'd160, data-FIFO fill level at which almost-full asserts.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_lr_data  in  134  packet word: [133:132] 01 head / 11 middle / 10 tail, [131:128] invalid-byte count, [127:0] data.
REQ-006 in_lr_data_wr  in  1  in_lr_data write strobe.
REQ-007 in_lr_data_valid  in  1  packet-valid flag.
REQ-008 in_lr_data_valid_wr  in  1  valid-flag strobe, coincident with the tail word.
REQ-009 out_lr_alf  out  1  almost-full to upstream; upstream starts no new packet while high.
REQ-010 in_local_mac_id  in  48  this node's MAC.
REQ-011 in_master_mac  in  48  master LCM MAC, destination of reports.
REQ-012 in_report_period  in  32  report interval in clk cycles; 0 disables reports.
REQ-013 in_local_time  in  32  local timestamp sampled into reports.
REQ-014 out_lu_data / out_lu_data_wr / out_lu_data_valid / out_lu_data_valid_wr  out  134/1/1/1  stream to lupdate, same encoding as input.
REQ-015 out_report_cnt  out  16  count of reports sent, wraps at 16'hFFFF->0.

Function
REQ-016 Data FIFO 256x134 and valid FIFO 16x1 SHALL buffer input; a valid-FIFO entry marks one complete stored packet.
REQ-017 out_lr_alf SHALL be 1 when data-FIFO used words >= ALF_TH or valid FIFO holds >= 14 entries, registered (1-cycle lag).
REQ-018 Write attempted while data FIFO full SHALL be discarded; no corruption of stored packets required beyond that packet.
REQ-019 Timer: counter increments each cycle; when counter >= in_report_period-1 and period != 0, set report_pending and clear counter; period 0 holds counter at 0 and does not set pending.
REQ-020 An expiry while report_pending is already set SHALL be coalesced (no second report).
REQ-021 FSM states IDLE, REPORT, FWD; IDLE drives all out_lu_* to 0 for at least one cycle between messages.
REQ-022 IDLE: report_pending -> REPORT (report has priority); else valid FIFO non-empty -> FWD; else stay.
REQ-023 REPORT emits 5 consecutive words, out_lu_data_wr=1 each cycle: W0 head 01, [127]=1 (locally generated), [7:0]=LMID, rest 0; W1 11, all 0; W2 11, [127:80]=in_master_mac, [79:32]=in_local_mac_id, [31:16]=16'h1662, [11:8]=4'he, rest 0; W3 11, [127:112]=out_report_cnt, [111:80]=in_local_time sampled at REPORT entry, [79:0]=0; W4 tail 10, [131:128]=4'h0, data 0.
REQ-024 On W4: out_lu_data_valid_wr=1, out_lu_data_valid=1; then clear report_pending, increment out_report_cnt, go IDLE.
REQ-025 FWD reads one packet from data FIFO, outputting words on consecutive cycles unchanged; on tail word pops valid FIFO, drives out_lu_data_valid_wr=1 with stored flag, goes IDLE.
REQ-026 Packets with valid flag 0 SHALL be forwarded unchanged (discard is downstream's job).
REQ-027 Timer expiry during FWD SHALL not interrupt the packet; report follows after IDLE.
REQ-028 Packet order SHALL be preserved; first output word of a packet SHALL appear no earlier than 2 cycles after its tail is written.

Reset
REQ-029 rst=1 SHALL immediately zero all out_lu_* outputs, out_report_cnt, timer, report_pending, set FSM IDLE, flush both FIFOs, out_lr_alf=0.
REQ-030 Reset mid-packet or mid-report SHALL abandon that message; no partial continuation after release.

Verification
REQ-031 period=100, no traffic -> 5-word report every 100+6 cycles max, W2[11:8]=4'he, W0[127]=1, out_report_cnt 0,1,2.
REQ-032 period=0, 3 packets of 4 words in -> same 3 packets out in order, bit-exact, valid flags preserved, ≥1 idle cycle between.
REQ-033 Expiry while a 90-word packet forwards -> packet completes intact, report follows it.
REQ-034 Continuous input to 160 stored words -> out_lr_alf=1; drains below -> 0.
REQ-035 Two expiries while pending (period=2, output blocked by long packet) -> exactly one report.
REQ-036 rst pulse at W2 of a report -> outputs 0 same cycle, next report W3 count field = 0.

Source files
------------

// File: rtl/lreport.sv
// lreport: buffers upstream packets in a data FIFO plus a per-packet valid FIFO,
// forwards complete packets to lupdate, and periodically injects a 5-word
// status report addressed to the master LCM. Reports win arbitration in IDLE
// but never interrupt a packet that is already being forwarded.
module lreport #(
    parameter logic [7:0] LMID   = 8'd12,
    parameter logic [8:0] ALF_TH = 9'd160
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] in_lr_data,
    input  logic         in_lr_data_wr,
    input  logic         in_lr_data_valid,
    input  logic         in_lr_data_valid_wr,
    output logic         out_lr_alf,
    input  logic [47:0]  in_local_mac_id,
    input  logic [47:0]  in_master_mac,
    input  logic [31:0]  in_report_period,
    input  logic [31:0]  in_local_time,
    output logic [133:0] out_lu_data,
    output logic         out_lu_data_wr,
    output logic         out_lu_data_valid,
    output logic         out_lu_data_valid_wr,
    output logic [15:0]  out_report_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPORT = 2'd1,
        FWD    = 2'd2
    } state_t;

    // Storage: 256-word data FIFO and 16-entry valid-flag FIFO. Pointers carry
    // one extra wrap bit so that used = wr - rd covers the full/empty cases.
    logic [133:0] dmem [0:255];
    logic         vmem [0:15];
    logic [8:0]   wr_ptr;
    logic [8:0]   rd_ptr;
    logic [8:0]   pkt_start;
    logic         drop;
    logic [4:0]   vwr_ptr;
    logic [4:0]   vrd_ptr;

    logic [8:0]   used;
    logic [4:0]   vused;
    logic         dfull;
    logic         vfull;

    // Write-side decode
    logic         is_head;
    logic [8:0]   start_eff;
    logic         drop_eff;
    logic         word_ok;
    logic         word_bad;
    logic         commit;
    logic         reject;

    // Timer
    logic [31:0]  timer;
    logic         pending;
    logic         expire;

    // Control
    state_t       state;
    state_t       state_nxt;
    logic [2:0]   idx;
    logic [2:0]   idx_nxt;
    logic [31:0]  stamp;
    logic         stamp_load;
    logic [133:0] rd_word;
    logic         vhead;
    logic [133:0] d_nxt;
    logic         wr_nxt;
    logic         v_nxt;
    logic         vwr_nxt;
    logic         rd_adv;
    logic         v_pop;
    logic         rpt_done;

    assign used    = wr_ptr - rd_ptr;
    assign vused   = vwr_ptr - vrd_ptr;
    assign dfull   = used[8];
    assign vfull   = vused[4];
    assign rd_word = dmem[rd_ptr[7:0]];
    assign vhead   = vmem[vrd_ptr[3:0]];
    assign expire  = (in_report_period != 32'd0) && (timer >= (in_report_period - 32'd1));

    // Assemble one word of the status report from its index.
    function automatic logic [133:0] report_word(
        input logic [2:0]  widx,
        input logic [47:0] master,
        input logic [47:0] local_mac,
        input logic [15:0] cnt,
        input logic [31:0] tstamp
    );
        logic [133:0] w;
        w = 134'd0;
        case (widx)
            3'd0: begin
                w[133:132] = 2'b01;
                w[127]     = 1'b1;
                w[7:0]     = LMID;
            end
            3'd1: begin
                w[133:132] = 2'b11;
            end
            3'd2: begin
                w[133:132] = 2'b11;
                w[127:80]  = master;
                w[79:32]   = local_mac;
                w[31:16]   = 16'h1662;
                w[11:8]    = 4'he;
            end
            3'd3: begin
                w[133:132] = 2'b11;
                w[127:112] = cnt;
                w[111:80]  = tstamp;
            end
            3'd4: begin
                w[133:132] = 2'b10;
            end
            default: begin
                w = 134'd0;
            end
        endcase
        return w;
    endfunction

    // Write-side decode: a packet that loses any word (data FIFO full) or finds
    // the valid FIFO full at its tail is rolled back to its head position, so a
    // partial packet is never handed to the reader.
    always_comb begin
        is_head   = (in_lr_data[133:132] == 2'b01);
        start_eff = pkt_start;
        drop_eff  = drop;
        if (in_lr_data_wr && is_head) begin
            start_eff = wr_ptr;
            drop_eff  = 1'b0;
        end else begin
            start_eff = pkt_start;
            drop_eff  = drop;
        end
        word_ok  = in_lr_data_wr && !dfull && !drop_eff;
        word_bad = in_lr_data_wr && (dfull || drop_eff);
        commit   = in_lr_data_valid_wr && !word_bad && !drop_eff && !vfull;
        reject   = in_lr_data_valid_wr && !commit;
    end

    // Data and valid FIFO storage arrays (no reset: emptiness comes from the pointers).
    always_ff @(posedge clk) begin
        if (word_ok) begin
            dmem[wr_ptr[7:0]] <= in_lr_data;
        end
        if (commit) begin
            vmem[vwr_ptr[3:0]] <= in_lr_data_valid;
        end
    end

    // FIFO pointers, per-packet drop tracking and the registered almost-full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= 9'd0;
            rd_ptr     <= 9'd0;
            pkt_start  <= 9'd0;
            drop       <= 1'b0;
            vwr_ptr    <= 5'd0;
            vrd_ptr    <= 5'd0;
            out_lr_alf <= 1'b0;
        end else begin
            if (reject) begin
                wr_ptr <= start_eff;
            end else if (word_ok) begin
                wr_ptr <= wr_ptr + 9'd1;
            end
            if (in_lr_data_wr && is_head) begin
                pkt_start <= wr_ptr;
            end
            if (in_lr_data_valid_wr) begin
                drop <= 1'b0;
            end else if (word_bad) begin
                drop <= 1'b1;
            end else begin
                drop <= drop_eff;
            end
            if (commit) begin
                vwr_ptr <= vwr_ptr + 5'd1;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + 9'd1;
            end
            if (v_pop) begin
                vrd_ptr <= vrd_ptr + 5'd1;
            end
            out_lr_alf <= (used >= ALF_TH) || (vused >= 5'd14);
        end
    end

    // Report timer; an expiry while a report is already pending is absorbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer   <= 32'd0;
            pending <= 1'b0;
        end else begin
            if ((in_report_period == 32'd0) || expire) begin
                timer <= 32'd0;
            end else begin
                timer <= timer + 32'd1;
            end
            if (rpt_done) begin
                pending <= 1'b0;
            end else if (expire) begin
                pending <= 1'b1;
            end
        end
    end

    // Next-state and next-output decode for the IDLE/REPORT/FWD controller.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        d_nxt      = 134'd0;
        wr_nxt     = 1'b0;
        v_nxt      = 1'b0;
        vwr_nxt    = 1'b0;
        rd_adv     = 1'b0;
        v_pop      = 1'b0;
        rpt_done   = 1'b0;
        stamp_load = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt = 3'd0;
                if (pending) begin
                    state_nxt  = REPORT;
                    stamp_load = 1'b1;
                end else if (vused != 5'd0) begin
                    state_nxt = FWD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            REPORT: begin
                d_nxt  = report_word(idx, in_master_mac, in_local_mac_id, out_report_cnt, stamp);
                wr_nxt = 1'b1;
                if (idx == 3'd4) begin
                    vwr_nxt   = 1'b1;
                    v_nxt     = 1'b1;
                    rpt_done  = 1'b1;
                    idx_nxt   = 3'd0;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + 3'd1;
                    state_nxt = REPORT;
                end
            end
            FWD: begin
                if (used == 9'd0) begin
                    state_nxt = IDLE;
                end else begin
                    d_nxt  = rd_word;
                    wr_nxt = 1'b1;
                    rd_adv = 1'b1;
                    if (rd_word[133:132] == 2'b10) begin
                        vwr_nxt   = 1'b1;
                        v_nxt     = vhead;
                        v_pop     = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FWD;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Controller state, report bookkeeping and registered output stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            idx                  <= 3'd0;
            stamp                <= 32'd0;
            out_report_cnt       <= 16'd0;
            out_lu_data          <= 134'd0;
            out_lu_data_wr       <= 1'b0;
            out_lu_data_valid    <= 1'b0;
            out_lu_data_valid_wr <= 1'b0;
        end else begin
            state                <= state_nxt;
            idx                  <= idx_nxt;
            if (stamp_load) begin
                stamp <= in_local_time;
            end
            if (rpt_done) begin
                out_report_cnt <= out_report_cnt + 16'd1;
            end
            out_lu_data          <= d_nxt;
            out_lu_data_wr       <= wr_nxt;
            out_lu_data_valid    <= v_nxt;
            out_lu_data_valid_wr <= vwr_nxt;
        end
    end

endmodule

// File: tb/tb_lreport.sv
// Testbench for lreport: directed phases with random packet contents, checked
// against an expected-message list built from the packet/report rules.
module tb_lreport;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [133:0] in_lr_data = '0;
    logic         in_lr_data_wr = 1'b0;
    logic         in_lr_data_valid = 1'b0;
    logic         in_lr_data_valid_wr = 1'b0;
    logic         out_lr_alf;
    logic [47:0]  in_local_mac_id = '0;
    logic [47:0]  in_master_mac = '0;
    logic [31:0]  in_report_period = '0;
    logic [31:0]  in_local_time = '0;
    logic [133:0] out_lu_data;
    logic         out_lu_data_wr;
    logic         out_lu_data_valid;
    logic         out_lu_data_valid_wr;
    logic [15:0]  out_report_cnt;

    lreport dut (
        .clk(clk), .rst(rst),
        .in_lr_data(in_lr_data), .in_lr_data_wr(in_lr_data_wr),
        .in_lr_data_valid(in_lr_data_valid), .in_lr_data_valid_wr(in_lr_data_valid_wr),
        .out_lr_alf(out_lr_alf),
        .in_local_mac_id(in_local_mac_id), .in_master_mac(in_master_mac),
        .in_report_period(in_report_period), .in_local_time(in_local_time),
        .out_lu_data(out_lu_data), .out_lu_data_wr(out_lu_data_wr),
        .out_lu_data_valid(out_lu_data_valid), .out_lu_data_valid_wr(out_lu_data_valid_wr),
        .out_report_cnt(out_report_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Observed messages
    logic [133:0] cur[$];
    logic [133:0] msgw[$];
    int           msgl[$];
    logic         msgv[$];
    int           msgt[$];
    int           cur_t = 0;
    logic         prev_wr = 1'b0;
    int           gap_err = 0;

    // Expected messages
    logic [133:0] expw[$];
    int           expl[$];
    logic         expv[$];

    logic [133:0] pkt[$];
    logic         pkt_v;
    int           tails[$];
    int           last_t;

    // Collect completed output messages; a reset discards any partial one.
    always @(negedge clk) begin
        if (rst) begin
            cur.delete();
            prev_wr <= 1'b0;
        end else begin
            if (out_lu_data_wr) begin
                if (cur.size() == 0) cur_t <= cyc;
                if (out_lu_data[133:132] == 2'b01 && prev_wr) gap_err <= gap_err + 1;
                cur.push_back(out_lu_data);
                if (out_lu_data_valid_wr) begin
                    foreach (cur[i]) msgw.push_back(cur[i]);
                    msgl.push_back(cur.size());
                    msgv.push_back(out_lu_data_valid);
                    msgt.push_back(cur_t);
                    cur.delete();
                end
            end
            prev_wr <= out_lu_data_wr;
        end
    end

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Build a random packet and append it to the expected list.
    task automatic make_pkt(input int len);
        logic [133:0] w;
        pkt.delete();
        pkt_v = 1'($urandom_range(0, 1));
        for (int i = 0; i < len; i++) begin
            w = {2'b11, 4'h0, rand128()};
            if (i == 0) begin
                w[133:132] = 2'b01;
                w[127] = 1'b0;
            end
            if (i == len - 1) begin
                w[133:132] = 2'b10;
                w[131:128] = 4'($urandom_range(0, 15));
            end
            pkt.push_back(w);
            expw.push_back(w);
        end
        expl.push_back(len);
        expv.push_back(pkt_v);
    endtask

    task automatic send(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            in_lr_data = pkt[i];
            in_lr_data_wr = 1'b1;
            in_lr_data_valid_wr = (i == pkt.size() - 1);
            in_lr_data_valid = (i == pkt.size() - 1) ? pkt_v : 1'b0;
            if (i == pkt.size() - 1) tails.push_back(cyc + 1);
        end
        @(negedge clk);
        in_lr_data = '0;
        in_lr_data_wr = 1'b0;
        in_lr_data_valid_wr = 1'b0;
        in_lr_data_valid = 1'b0;
    endtask

    // Expected report: head with local marker and ID, then addressing, counter and time.
    task automatic exp_report(input logic [15:0] cnt);
        logic [133:0] w;
        w = '0; w[133:132] = 2'b01; w[127] = 1'b1; w[7:0] = 8'd12; expw.push_back(w);
        w = '0; w[133:132] = 2'b11; expw.push_back(w);
        w = '0; w[133:132] = 2'b11; w[127:80] = in_master_mac; w[79:32] = in_local_mac_id;
        w[31:16] = 16'h1662; w[11:8] = 4'he; expw.push_back(w);
        w = '0; w[133:132] = 2'b11; w[127:112] = cnt; w[111:80] = in_local_time; expw.push_back(w);
        w = '0; w[133:132] = 2'b10; expw.push_back(w);
        expl.push_back(5);
        expv.push_back(1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_msgs(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (msgl.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk({tag, "_arrived"}, 134'(msgl.size() >= n), 134'(1));
    endtask

    task automatic cmp_next(input string tag);
        int el, gl;
        logic [133:0] g;
        chk({tag, "_present"}, 134'(msgl.size() > 0), 134'(1));
        if (msgl.size() > 0 && expl.size() > 0) begin
            el = expl.pop_front();
            gl = msgl.pop_front();
            last_t = msgt.pop_front();
            chk({tag, "_len"}, 134'(gl), 134'(el));
            chk({tag, "_valid"}, 134'(msgv.pop_front()), 134'(expv.pop_front()));
            for (int i = 0; i < el; i++) begin
                g = (i < gl && msgw.size() > 0) ? msgw.pop_front() : {134{1'b1}};
                chk($sformatf("%s_w%0d", tag, i), g, expw.pop_front());
            end
            for (int i = el; i < gl; i++) void'(msgw.pop_front());
        end
    endtask

    initial begin
        int t_rep[3];
        int found;
        in_master_mac = {$urandom(), 16'($urandom())};
        in_local_mac_id = {$urandom(), 16'($urandom())};
        in_local_time = $urandom();

        // Reset state
        #1;
        chk("rst_data", out_lu_data, 134'd0);
        chk("rst_wr", 134'(out_lu_data_wr), 134'd0);
        chk("rst_vwr", 134'(out_lu_data_valid_wr), 134'd0);
        chk("rst_cnt", 134'(out_report_cnt), 134'd0);
        chk("rst_alf", 134'(out_lr_alf), 134'd0);
        idle(3);
        rst = 1'b0;
        idle(3);

        // Three 4-word packets, no reports: bit-exact, in order, latency >= 2
        for (int p = 0; p < 3; p++) begin
            make_pkt(4);
            send(0, 4);
        end
        wait_msgs("fwd3", 3, 100);
        for (int p = 0; p < 3; p++) begin
            cmp_next($sformatf("fwd3_p%0d", p));
            chk($sformatf("fwd3_lat%0d", p), 134'((last_t - tails[p]) >= 2), 134'(1));
        end
        tails.delete();

        // Periodic reports with no traffic
        @(negedge clk);
        in_report_period = 32'd100;
        found = cyc;
        for (int r = 0; r < 3; r++) exp_report(16'(r));
        wait_msgs("rep3", 3, 400);
        in_report_period = 32'd0;
        for (int r = 0; r < 3; r++) begin
            cmp_next($sformatf("rep3_r%0d", r));
            t_rep[r] = last_t;
        end
        chk("rep3_first", 134'((t_rep[0] - found) <= 106), 134'(1));
        chk("rep3_int1", 134'((t_rep[1] - t_rep[0]) <= 106 && (t_rep[1] - t_rep[0]) >= 94), 134'(1));
        chk("rep3_int2", 134'((t_rep[2] - t_rep[1]) <= 106 && (t_rep[2] - t_rep[1]) >= 94), 134'(1));
        idle(20);

        // Expiry during a 90-word packet: packet intact, then one report
        make_pkt(90);
        send(0, 90);
        in_report_period = 32'd30;
        idle(70);
        in_report_period = 32'd0;
        exp_report(16'd3);
        wait_msgs("long90", 2, 300);
        cmp_next("long90_pkt");
        cmp_next("long90_rep");
        idle(20);
        chk("long90_extra", 134'(msgl.size()), 134'(0));

        // Repeated expiries while pending coalesce into one report
        make_pkt(60);
        send(0, 60);
        in_report_period = 32'd2;
        idle(20);
        in_report_period = 32'd0;
        exp_report(16'd4);
        wait_msgs("coal", 2, 300);
        cmp_next("coal_pkt");
        cmp_next("coal_rep");
        idle(20);
        chk("coal_extra", 134'(msgl.size()), 134'(0));
        chk("coal_cnt", 134'(out_report_cnt), 134'(5));

        // Almost-full threshold at 160 stored words
        make_pkt(170);
        send(0, 159);
        @(negedge clk);
        chk("alf_159", 134'(out_lr_alf), 134'(0));
        send(159, 160);
        @(negedge clk);
        chk("alf_160", 134'(out_lr_alf), 134'(1));
        send(160, 170);
        wait_msgs("alf_pkt", 1, 400);
        cmp_next("alf_pkt");
        idle(3);
        chk("alf_drain", 134'(out_lr_alf), 134'(0));

        // Reset in the middle of a report
        @(negedge clk);
        in_report_period = 32'd50;
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (out_lu_data_wr && out_lu_data[133:132] == 2'b01 && out_lu_data[127]) found = 1;
        end
        chk("mid_rep_seen", 134'(found), 134'(1));
        idle(2);
        chk("mid_rep_w2", 134'(out_lu_data[11:8]), 134'(4'he));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_data", out_lu_data, 134'd0);
        chk("mid_rst_wr", 134'(out_lu_data_wr), 134'd0);
        chk("mid_rst_cnt", 134'(out_report_cnt), 134'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        exp_report(16'd0);
        wait_msgs("post_rst", 1, 200);
        in_report_period = 32'd0;
        cmp_next("post_rst_rep");
        idle(20);
        chk("final_extra", 134'(msgl.size()), 134'(0));
        chk("gap_errors", 134'(gap_err), 134'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
